// File: rtl/riscuinho_lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents:
//   - RV32I funct3 encodings for loads and stores.
//   - Bus size codes: byte, half, word.
//   - FSM state encodings: IDLE, CHECK, WAIT, XFER, RESP.
//   - Helper functions: access-fault check and funct3-to-size mapping.
package riscuinho_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // An illegal encoding is reported the same way as a misaligned address.
  // The unsigned loads (LBU/LHU) have no store form, so a store with
  // either encoding is also treated as a fault.
  function automatic logic access_fault(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    return 1'b0;
      F3_H:    return addr_lo[0];
      F3_W:    return |addr_lo;
      F3_BU:   return we;
      F3_HU:   return we | addr_lo[0];
      default: return 1'b1;
    endcase
  endfunction

  // Map the low two funct3 bits to a bus size code. Encodings that fault
  // map to word; no bus access is ever made for them.
  function automatic logic [1:0] size_of(input logic [1:0] funct3_lo);
    case (funct3_lo)
      2'b00:   return SIZE_BYTE;
      2'b01:   return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Interface to the data bus controller.
// Signals:
//   rd, wd  : read / write strobes toward the controller
//   size    : access size code (00 byte, 01 half, 10 word)
//   addr    : byte address
//   wdata   : store data
//   rdata   : load data from the controller (low-aligned, zero-filled)
//   ready   : controller ready
//   busy    : controller busy
// Modports:
//   master : the load/store unit side
//   slave  : the controller side
interface load_store_unit_if;
  logic        rd;
  logic        wd;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;

  modport master (output rd, wd, size, addr, wdata, input rdata, ready, busy);
  modport slave  (input rd, wd, size, addr, wdata, output rdata, ready, busy);
endinterface

// File: rtl/lsu_load_extend.sv
// Load data extension.
// Purely combinational: sign- or zero-extends the low byte or halfword of
// the captured bus data according to the load funct3.
// Ports:
//   funct3 : in  3  load encoding
//   data   : in  32 captured bus data
//   ext    : out 32 extended result
module lsu_load_extend
  import riscuinho_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (funct3)
      F3_B:    ext = {{24{data[7]}}, data[7:0]};
      F3_BU:   ext = {24'b0, data[7:0]};
      F3_H:    ext = {{16{data[15]}}, data[15:0]};
      F3_HU:   ext = {16'b0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: CPU-side front end for the data bus controller.
// Behaviour:
//   - Accepts one RV32I load/store per handshake.
//   - Checks alignment in CHECK.
//   - Waits for a bus grant (ready & !busy) in WAIT, with a timeout.
//   - Strobes the bus for exactly one cycle in XFER.
//   - Returns a one-cycle response in RESP.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_we/funct3     : store flag and access encoding
//   req_addr/wdata    : request address and store data
//   resp_valid        : one-cycle response pulse
//   resp_rdata        : extended load data (0 for stores/faults)
//   resp_misalign     : alignment / illegal-encoding fault
//   resp_timeout      : no bus grant within TIMEOUT_CYCLES
//   bus               : controller interface (master side)
module load_store_unit
  import riscuinho_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_misalign,
  output logic                     resp_timeout,
  load_store_unit_if.master        bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [2:0]           state_reg, state_next;
  logic                 we_reg;
  logic [2:0]           funct3_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [31:0]          rdata_reg;
  logic                 misalign_reg;
  logic                 timeout_reg;
  logic [31:0]          bus_addr_reg;
  logic [1:0]           bus_size_reg;
  logic [31:0]          bus_wdata_reg;
  logic                 grant;
  logic [31:0]          ext_data;

  assign grant = bus.ready & ~bus.busy;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = ST_CHECK;
      ST_CHECK: state_next = access_fault(we_reg, funct3_reg, bus_addr_reg[1:0])
                             ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (grant)                  state_next = ST_XFER;
        else if (cnt_reg == CNT_LAST) state_next = ST_RESP;
      end
      ST_XFER:  state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      cnt_reg       <= '0;
      rdata_reg     <= 32'h0;
      misalign_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      bus_addr_reg  <= 32'h0;
      bus_size_reg  <= SIZE_WORD;
      bus_wdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg        <= req_we;
            funct3_reg    <= req_funct3;
            bus_addr_reg  <= req_addr;
            bus_wdata_reg <= req_wdata;
            bus_size_reg  <= size_of(req_funct3[1:0]);
            cnt_reg       <= '0;
            misalign_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
          end
        end
        ST_CHECK: misalign_reg <= access_fault(we_reg, funct3_reg, bus_addr_reg[1:0]);
        ST_WAIT: begin
          // Counter value equals the number of ungranted WAIT cycles so far;
          // the last allowed one flags the timeout on its way to RESP.
          if (!grant) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            if (cnt_reg == CNT_LAST) timeout_reg <= 1'b1;
          end
        end
        ST_XFER: if (!we_reg) rdata_reg <= bus.rdata;
        default: ;
      endcase
    end
  end

  lsu_load_extend u_extend (
    .funct3 (funct3_reg),
    .data   (rdata_reg),
    .ext    (ext_data)
  );

  // Outputs decode from registered state, so an asynchronous reset forces
  // them to their idle values immediately.
  assign req_ready     = (state_reg == ST_IDLE);
  assign resp_valid    = (state_reg == ST_RESP);
  assign resp_misalign = resp_valid & misalign_reg;
  assign resp_timeout  = resp_valid & timeout_reg;
  assign resp_rdata    = (resp_valid && !we_reg && !misalign_reg && !timeout_reg)
                         ? ext_data : 32'h0;

  assign bus.rd    = (state_reg == ST_XFER) & ~we_reg;
  assign bus.wd    = (state_reg == ST_XFER) & we_reg;
  assign bus.size  = bus_size_reg;
  assign bus.addr  = bus_addr_reg;
  assign bus.wdata = bus_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_timeout;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .resp_timeout  (resp_timeout),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    logic        timeout;
    int          latency;
    int          n_rd;
    int          n_wd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, let the bench act as the bus controller, and compare
  // the response against the scoreboard entry pushed at drive time.
  task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] bus_data, input int busy_cycles,
                         input logic [31:0] exp_rdata, input logic exp_mis,
                         input logic exp_to, input int exp_lat);
    exp_t e;
    exp_t p;
    int   cyc;
    int   n_rd;
    int   n_wd;
    logic got;
    e.rdata    = exp_rdata;
    e.misalign = exp_mis;
    e.timeout  = exp_to;
    e.latency  = exp_lat;
    e.n_rd     = (!we && !exp_mis && !exp_to) ? 1 : 0;
    e.n_wd     = (we && !exp_mis && !exp_to) ? 1 : 0;
    e.size     = (f3[1:0] == 2'b00) ? 2'b00 : (f3[1:0] == 2'b01) ? 2'b01 : 2'b10;
    e.addr     = addr;
    e.wdata    = wdata;
    sb_q.push_back(e);

    @(negedge clk);
    check_eq({name, "/ready_idle"}, 32'(req_ready), 32'd1);
    req_valid     = 1'b1;
    req_we        = we;
    req_funct3    = f3;
    req_addr      = addr;
    req_wdata     = wdata;
    bus_if.rdata  = bus_data;
    bus_if.ready  = 1'b1;
    bus_if.busy   = (busy_cycles > 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hFFFF_FFFF;

    cyc  = 0;
    n_rd = 0;
    n_wd = 0;
    got  = 1'b0;
    p    = e;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      bus_if.busy = (cyc <= busy_cycles);
      if (bus_if.rd) begin
        n_rd++;
        check_eq({name, "/rd_size"}, 32'(bus_if.size), 32'(e.size));
        check_eq({name, "/rd_addr"}, bus_if.addr, e.addr);
      end
      if (bus_if.wd) begin
        n_wd++;
        check_eq({name, "/wd_size"}, 32'(bus_if.size), 32'(e.size));
        check_eq({name, "/wd_addr"}, bus_if.addr, e.addr);
        check_eq({name, "/wd_data"}, bus_if.wdata, e.wdata);
      end
      if (resp_valid) begin
        got = 1'b1;
        p = sb_q.pop_front();
        check_eq({name, "/rdata"},    resp_rdata, p.rdata);
        check_eq({name, "/misalign"}, 32'(resp_misalign), 32'(p.misalign));
        check_eq({name, "/timeout"},  32'(resp_timeout), 32'(p.timeout));
        check_eq({name, "/latency"},  32'(cyc - 1), 32'(p.latency));
        check_eq({name, "/ready_resp"}, 32'(req_ready), 32'd0);
      end
    end
    check_eq({name, "/resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      check_eq({name, "/n_rd"}, 32'(n_rd), 32'(p.n_rd));
      check_eq({name, "/n_wd"}, 32'(n_wd), 32'(p.n_wd));
      @(negedge clk);
      check_eq({name, "/resp_pulse"}, 32'(resp_valid), 32'd0);
      check_eq({name, "/ready_after"}, 32'(req_ready), 32'd1);
    end
    bus_if.busy = 1'b0;
    $display("txn %-8s we=%0b f3=%03b addr=%08h lat=%0d rdata=%08h mis=%0b to=%0b rd=%0d wd=%0d",
             name, we, f3, addr, cyc - 1, resp_rdata, resp_misalign, resp_timeout, n_rd, n_wd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "/req_ready"},  32'(req_ready), 32'd1);
    check_eq({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "/resp_rdata"}, resp_rdata, 32'h0);
    check_eq({tag, "/resp_mis"},   32'(resp_misalign), 32'd0);
    check_eq({tag, "/resp_to"},    32'(resp_timeout), 32'd0);
    check_eq({tag, "/bus_rd"},     32'(bus_if.rd), 32'd0);
    check_eq({tag, "/bus_wd"},     32'(bus_if.wd), 32'd0);
    check_eq({tag, "/bus_size"},   32'(bus_if.size), 32'd2);
    check_eq({tag, "/bus_addr"},   bus_if.addr, 32'h0);
    check_eq({tag, "/bus_wdata"},  bus_if.wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stray;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    bus_if.rdata = 32'h0;
    bus_if.ready = 1'b1;
    bus_if.busy  = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    //       name      we    f3      addr          wdata         bus_rdata     busy rdata         mis   to    lat
    run_txn("lw",     1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h8000_00F1, 0, 32'h8000_00F1, 1'b0, 1'b0, 3);
    run_txn("lb",     1'b0, 3'b000, 32'h0000_0011, 32'h0,        32'h0000_0080, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 3);
    run_txn("lbu",    1'b0, 3'b100, 32'h0000_0011, 32'h0,        32'h0000_0080, 0, 32'h0000_0080, 1'b0, 1'b0, 3);
    run_txn("sh",     1'b1, 3'b001, 32'h0000_0020, 32'h1234_ABCD, 32'h5555_5555, 0, 32'h0,        1'b0, 1'b0, 3);
    run_txn("lw_mis", 1'b0, 3'b010, 32'h0000_0022, 32'h0,        32'h1111_1111, 0, 32'h0,         1'b1, 1'b0, 1);
    run_txn("lh",     1'b0, 3'b001, 32'h0000_0032, 32'h0,        32'hABCD_8001, 0, 32'hFFFF_8001, 1'b0, 1'b0, 3);
    run_txn("lhu",    1'b0, 3'b101, 32'h0000_0032, 32'h0,        32'hABCD_8001, 0, 32'h0000_8001, 1'b0, 1'b0, 3);
    run_txn("sw",     1'b1, 3'b010, 32'h0000_0044, 32'hDEAD_BEEF, 32'h0,        0, 32'h0,         1'b0, 1'b0, 3);
    run_txn("f3_011", 1'b0, 3'b011, 32'h0000_0048, 32'h0,        32'h2222_2222, 0, 32'h0,         1'b1, 1'b0, 1);
    run_txn("sbu_ill",1'b1, 3'b100, 32'h0000_0049, 32'h7777_7777, 32'h0,        0, 32'h0,         1'b1, 1'b0, 1);
    run_txn("lh_mis", 1'b0, 3'b001, 32'h0000_0031, 32'h0,        32'h3333_3333, 0, 32'h0,         1'b1, 1'b0, 1);
    run_txn("lw_to",  1'b0, 3'b010, 32'h0000_0050, 32'h0,        32'h4444_4444, 20, 32'h0,        1'b0, 1'b1, 17);
    run_txn("lw_bsy", 1'b0, 3'b010, 32'h0000_0060, 32'h0,        32'h1357_9BDF, 3, 32'h1357_9BDF, 1'b0, 1'b0, 5);
    run_txn("lb_pos", 1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'h0000_007F, 0, 32'h0000_007F, 1'b0, 1'b0, 3);
    run_txn("sb",     1'b1, 3'b000, 32'h0000_0015, 32'hA5A5_A5A5, 32'h0,        0, 32'h0,         1'b0, 1'b0, 3);

    // Reset asserted while the unit sits in WAIT on a busy bus.
    @(negedge clk);
    req_valid   = 1'b1;
    req_we      = 1'b1;
    req_funct3  = 3'b010;
    req_addr    = 32'h0000_0070;
    req_wdata   = 32'hCAFE_F00D;
    bus_if.busy = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid/in_wait_ready", 32'(req_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    rst = 1'b0;
    bus_if.busy = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || bus_if.rd || bus_if.wd) stray++;
    end
    check_eq("mid/no_resp", 32'(stray), 32'd0);
    $display("txn %-8s reset during WAIT, stray_events=%0d", "rst_mid", stray);

    run_txn("lw_post", 1'b0, 3'b010, 32'h0000_0080, 32'h0,       32'h0BAD_CAFE, 0, 32'h0BAD_CAFE, 1'b0, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
